decode_pipe: RTL and testbench

DECODE_PIPE -- requirements
Module: decode_pipe

---
 rtl/decode_pipe.sv | 181 ++++++++++++++++++
 tb/tb_decode_pipe.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_pipe.sv
// decode_pipe: single-stage MIPS-subset instruction decoder with a registered
// output bundle, execute-side backpressure, flush, and load-use hazard detect.
module decode_pipe #(
  parameter int XLEN   = 32,
  parameter int EXT_EN = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      out_op,
  output logic [4:0]      out_a1,
  output logic [4:0]      out_a2,
  output logic [4:0]      out_a3,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_pc,
  output logic            hazard
);

  localparam bit L_EXT = (EXT_EN != 0);

  localparam logic [4:0] OP_NOP  = 5'd0;
  localparam logic [4:0] OP_ADDU = 5'd1;
  localparam logic [4:0] OP_SUBU = 5'd2;
  localparam logic [4:0] OP_SLT  = 5'd3;
  localparam logic [4:0] OP_JR   = 5'd4;
  localparam logic [4:0] OP_ADDI = 5'd5;
  localparam logic [4:0] OP_ADDIU= 5'd6;
  localparam logic [4:0] OP_ORI  = 5'd7;
  localparam logic [4:0] OP_LW   = 5'd8;
  localparam logic [4:0] OP_SW   = 5'd9;
  localparam logic [4:0] OP_BEQ  = 5'd10;
  localparam logic [4:0] OP_LUI  = 5'd11;
  localparam logic [4:0] OP_J    = 5'd12;
  localparam logic [4:0] OP_JAL  = 5'd13;
  localparam logic [4:0] OP_AND  = 5'd14;
  localparam logic [4:0] OP_OR   = 5'd15;
  localparam logic [4:0] OP_SLL  = 5'd16;
  localparam logic [4:0] OP_BNE  = 5'd17;
  localparam logic [4:0] OP_ILL  = 5'd31;

  function automatic logic [XLEN-1:0] sext16(input logic [15:0] v);
    return XLEN'($signed(v));
  endfunction

  function automatic logic [XLEN-1:0] zext16(input logic [15:0] v);
    return XLEN'(v);
  endfunction

  logic [5:0]      w_opc;
  logic [5:0]      w_fn;
  logic [4:0]      w_a1;
  logic [4:0]      w_a2;
  logic [4:0]      w_rd;
  logic [4:0]      w_op;
  logic [4:0]      w_a3;
  logic [XLEN-1:0] w_imm;
  logic            w_rs_rd;
  logic            w_rt_rd;
  logic            w_adv;

  logic            r_vld_p1;
  logic [4:0]      r_op_p1;
  logic [4:0]      r_a1_p1;
  logic [4:0]      r_a2_p1;
  logic [4:0]      r_a3_p1;
  logic [XLEN-1:0] r_imm_p1;
  logic [XLEN-1:0] r_pc_p1;

  assign w_opc = in_instr[31:26];
  assign w_fn  = in_instr[5:0];
  assign w_a1  = in_instr[25:21];
  assign w_a2  = in_instr[20:16];
  assign w_rd  = in_instr[15:11];

  // Decode the incoming word into op, destination and immediate/target.
  always_comb begin
    w_op  = OP_ILL;
    w_a3  = '0;
    w_imm = '0;
    if (in_instr == 32'h0) begin
      w_op = OP_NOP;
    end else if (w_opc == 6'h00) begin
      case (w_fn)
        6'h21: begin w_op = OP_ADDU; w_a3 = w_rd; end
        6'h23: begin w_op = OP_SUBU; w_a3 = w_rd; end
        6'h2A: begin w_op = OP_SLT;  w_a3 = w_rd; end
        6'h08: w_op = OP_JR;
        6'h24: if (L_EXT) begin w_op = OP_AND; w_a3 = w_rd; end
        6'h25: if (L_EXT) begin w_op = OP_OR;  w_a3 = w_rd; end
        6'h00: if (L_EXT) begin
          w_op  = OP_SLL;
          w_a3  = w_rd;
          w_imm = XLEN'(in_instr[10:6]);
        end
        default: ;
      endcase
    end else begin
      case (w_opc)
        6'h08: begin w_op = OP_ADDI;  w_a3 = w_a2; w_imm = sext16(in_instr[15:0]); end
        6'h09: begin w_op = OP_ADDIU; w_a3 = w_a2; w_imm = sext16(in_instr[15:0]); end
        6'h0D: begin w_op = OP_ORI;   w_a3 = w_a2; w_imm = zext16(in_instr[15:0]); end
        6'h23: begin w_op = OP_LW;    w_a3 = w_a2; w_imm = sext16(in_instr[15:0]); end
        6'h2B: begin w_op = OP_SW;    w_imm = sext16(in_instr[15:0]); end
        6'h04: begin w_op = OP_BEQ;   w_imm = sext16(in_instr[15:0]); end
        6'h05: if (L_EXT) begin w_op = OP_BNE; w_imm = sext16(in_instr[15:0]); end
        6'h0F: begin w_op = OP_LUI; w_a3 = w_a2; w_imm[31:16] = in_instr[15:0]; end
        6'h02: begin w_op = OP_J;   w_imm = {in_pc[XLEN-1:28], in_instr[25:0], 2'b00}; end
        6'h03: begin
          w_op  = OP_JAL;
          w_a3  = 5'd31;
          w_imm = {in_pc[XLEN-1:28], in_instr[25:0], 2'b00};
        end
        default: ;
      endcase
    end
  end

  // Derive which source registers the decoded op actually reads.
  always_comb begin
    w_rs_rd = 1'b0;
    w_rt_rd = 1'b0;
    case (w_op)
      OP_ADDU, OP_SUBU, OP_SLT, OP_JR, OP_AND, OP_OR: begin w_rs_rd = 1'b1; w_rt_rd = 1'b1; end
      OP_SLL: w_rt_rd = 1'b1;
      OP_SW, OP_BEQ, OP_BNE: begin w_rs_rd = 1'b1; w_rt_rd = 1'b1; end
      OP_ADDI, OP_ADDIU, OP_ORI, OP_LW, OP_LUI: w_rs_rd = 1'b1;
      default: ;
    endcase
  end

  // A load to $0 never stalls: its result is architecturally discarded.
  assign hazard = r_vld_p1 & (r_op_p1 == OP_LW) & (r_a3_p1 != 5'd0) & in_valid &
                  ((w_rs_rd & (w_a1 == r_a3_p1)) | (w_rt_rd & (w_a2 == r_a3_p1)));

  assign w_adv    = (~r_vld_p1 | out_ready) & ~flush;
  assign in_ready = w_adv & ~hazard;

  // Output register: flush kills, advance loads a beat or a bubble, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1 <= 1'b0;
      r_op_p1  <= OP_NOP;
      r_a1_p1  <= '0;
      r_a2_p1  <= '0;
      r_a3_p1  <= '0;
      r_imm_p1 <= '0;
      r_pc_p1  <= '0;
    end else if (flush) begin
      r_vld_p1 <= 1'b0;
      r_op_p1  <= OP_NOP;
    end else if (w_adv) begin
      if (in_valid && !hazard) begin
        r_vld_p1 <= 1'b1;
        r_op_p1  <= w_op;
        r_a1_p1  <= w_a1;
        r_a2_p1  <= w_a2;
        r_a3_p1  <= w_a3;
        r_imm_p1 <= w_imm;
        r_pc_p1  <= in_pc;
      end else begin
        r_vld_p1 <= 1'b0;
        r_op_p1  <= OP_NOP;
      end
    end
  end

  assign out_valid = r_vld_p1;
  assign out_op    = r_op_p1;
  assign out_a1    = r_a1_p1;
  assign out_a2    = r_a2_p1;
  assign out_a3    = r_a3_p1;
  assign out_imm   = r_imm_p1;
  assign out_pc    = r_pc_p1;

endmodule

// File: tb/tb_decode_pipe.sv
// tb_decode_pipe: directed scoreboard bench for decode_pipe (EXT_EN=1 and 0).
module tb_decode_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_ready;

  logic        in_ready, out_valid, hazard;
  logic [4:0]  out_op, out_a1, out_a2, out_a3;
  logic [31:0] out_imm, out_pc;

  logic        in_ready0, out_valid0, hazard0;
  logic [4:0]  out_op0, out_a10, out_a20, out_a30;
  logic [31:0] out_imm0, out_pc0;

  decode_pipe #(.XLEN(32), .EXT_EN(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
    .out_a1(out_a1), .out_a2(out_a2), .out_a3(out_a3),
    .out_imm(out_imm), .out_pc(out_pc), .hazard(hazard)
  );

  decode_pipe #(.XLEN(32), .EXT_EN(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .out_valid(out_valid0), .out_ready(out_ready), .out_op(out_op0),
    .out_a1(out_a10), .out_a2(out_a20), .out_a3(out_a30),
    .out_imm(out_imm0), .out_pc(out_pc0), .hazard(hazard0)
  );

  typedef struct {
    logic [4:0]  op;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [4:0]  a3;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [4:0]  op0;
    logic [4:0]  a3_0;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input logic [4:0] op, input logic [4:0] a1, input logic [4:0] a2,
                      input logic [4:0] a3, input logic [31:0] imm, input logic [31:0] pc,
                      input logic [4:0] op0, input logic [4:0] a3_0);
    exp_t e;
    e.op = op; e.a1 = a1; e.a2 = a2; e.a3 = a3;
    e.imm = imm; e.pc = pc; e.op0 = op0; e.a3_0 = a3_0;
    q.push_back(e);
  endtask

  task automatic expect_out(input string tag);
    exp_t e;
    chk({tag, ".valid"}, out_valid, 1'b1);
    chk({tag, ".valid0"}, out_valid0, 1'b1);
    n_cmp++;
    assert (q.size() != 0) else begin
      n_err++;
      $error("FAIL %s.scoreboard: observed empty queue expected an entry", tag);
    end
    if (q.size() != 0) begin
      e = q.pop_front();
      chk({tag, ".op"},  out_op,  e.op);
      chk({tag, ".a1"},  out_a1,  e.a1);
      chk({tag, ".a2"},  out_a2,  e.a2);
      chk({tag, ".a3"},  out_a3,  e.a3);
      chk({tag, ".imm"}, out_imm, e.imm);
      chk({tag, ".pc"},  out_pc,  e.pc);
      chk({tag, ".op0"}, out_op0, e.op0);
      chk({tag, ".a3_0"}, out_a30, e.a3_0);
    end
  endtask

  // Drive one accepted beat, then check the registered result one cycle later.
  task automatic beat(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                      input logic [4:0] op, input logic [4:0] a1, input logic [4:0] a2,
                      input logic [4:0] a3, input logic [31:0] imm,
                      input logic [4:0] op0, input logic [4:0] a3_0);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    push(op, a1, a2, a3, imm, pc, op0, a3_0);
    #1;
    chk({tag, ".in_ready"}, in_ready, 1'b1);
    cyc();
    in_valid = 1'b0;
    expect_out(tag);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".valid"}, out_valid, 1'b0);
    chk({tag, ".op"},    out_op,    5'd0);
    chk({tag, ".a1"},    out_a1,    5'd0);
    chk({tag, ".a2"},    out_a2,    5'd0);
    chk({tag, ".a3"},    out_a3,    5'd0);
    chk({tag, ".imm"},   out_imm,   32'd0);
    chk({tag, ".pc"},    out_pc,    32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = 32'h0;
    in_pc     = 32'h0;
    flush     = 1'b0;
    out_ready = 1'b1;

    // Reset state.
    #12;
    chk_zero("rst");
    chk("rst.valid0", out_valid0, 1'b0);
    chk("rst.op0",    out_op0,    5'd0);
    chk("rst.a1_0",   out_a10,    5'd0);
    chk("rst.a2_0",   out_a20,    5'd0);
    chk("rst.imm0",   out_imm0,   32'd0);
    chk("rst.pc0",    out_pc0,    32'd0);
    chk("rst.in_ready",  in_ready,  1'b1);
    chk("rst.in_ready0", in_ready0, 1'b1);
    chk("rst.hazard",    hazard,    1'b0);
    chk("rst.hazard0",   hazard0,   1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back decode of assorted encodings.
    beat("addu", 32'h00851021, 32'h00001000, 5'd1,  5'd4,  5'd5, 5'd2,  32'h0,        5'd1,  5'd2);
    beat("jal",  32'h0C000100, 32'h40000000, 5'd13, 5'd0,  5'd0, 5'd31, 32'h40000400, 5'd13, 5'd31);
    beat("and",  32'h00430824, 32'h00001008, 5'd14, 5'd2,  5'd3, 5'd1,  32'h0,        5'd31, 5'd0);
    beat("ori",  32'h34C58001, 32'h0000100C, 5'd7,  5'd6,  5'd5, 5'd5,  32'h00008001, 5'd7,  5'd5);
    beat("lui",  32'h3C071234, 32'h00001010, 5'd11, 5'd0,  5'd7, 5'd7,  32'h12340000, 5'd11, 5'd7);
    beat("sll",  32'h000520C0, 32'h00001014, 5'd16, 5'd0,  5'd5, 5'd4,  32'h3,        5'd31, 5'd0);
    beat("ill",  32'hFC000000, 32'h00001018, 5'd31, 5'd0,  5'd0, 5'd0,  32'h0,        5'd31, 5'd0);
    beat("nop",  32'h00000000, 32'h0000101C, 5'd0,  5'd0,  5'd0, 5'd0,  32'h0,        5'd0,  5'd0);
    beat("sw",   32'hAC620008, 32'h00001020, 5'd9,  5'd3,  5'd2, 5'd0,  32'h8,        5'd9,  5'd0);
    beat("jr",   32'h03E00008, 32'h00001024, 5'd4,  5'd31, 5'd0, 5'd0,  32'h0,        5'd4,  5'd0);
    beat("beq",  32'h1022FFFF, 32'h00001028, 5'd10, 5'd1,  5'd2, 5'd0,  32'hFFFFFFFF, 5'd10, 5'd0);
    beat("bne",  32'h14220004, 32'h0000102C, 5'd17, 5'd1,  5'd2, 5'd0,  32'h4,        5'd31, 5'd0);

    // Load-use hazard: stall, bubble, then the dependent op issues.
    beat("lw",   32'h8D28FFFC, 32'h00002000, 5'd8,  5'd9,  5'd8, 5'd8,  32'hFFFFFFFC, 5'd8,  5'd8);
    in_valid = 1'b1;
    in_instr = 32'h01011821;
    in_pc    = 32'h00002004;
    #1;
    chk("haz.hazard",   hazard,   1'b1);
    chk("haz.in_ready", in_ready, 1'b0);
    cyc();
    chk("bubble.valid",    out_valid, 1'b0);
    chk("bubble.op",       out_op,    5'd0);
    chk("bubble.hazard",   hazard,    1'b0);
    chk("bubble.in_ready", in_ready,  1'b1);
    push(5'd1, 5'd8, 5'd1, 5'd3, 32'h0, 32'h00002004, 5'd1, 5'd3);
    cyc();
    in_valid = 1'b0;
    expect_out("haz_addu");

    // A load to $0 never stalls its consumer.
    beat("lw0",  32'h8D200000, 32'h00002010, 5'd8,  5'd9,  5'd0, 5'd0,  32'h0,        5'd8,  5'd0);
    in_valid = 1'b1;
    in_instr = 32'h00001821;
    in_pc    = 32'h00002014;
    push(5'd1, 5'd0, 5'd0, 5'd3, 32'h0, 32'h00002014, 5'd1, 5'd3);
    #1;
    chk("lw0.hazard",   hazard,   1'b0);
    chk("lw0.in_ready", in_ready, 1'b1);
    cyc();
    in_valid = 1'b0;
    expect_out("lw0_addu");

    // Backpressure: output held for three cycles, input not accepted.
    beat("ori2", 32'h34C58001, 32'h00003000, 5'd7,  5'd6,  5'd5, 5'd5,  32'h00008001, 5'd7,  5'd5);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'hAC620008;
    in_pc     = 32'h00003004;
    #1;
    chk("bp.in_ready0", in_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("bp.valid",    out_valid, 1'b1);
      chk("bp.op",       out_op,    5'd7);
      chk("bp.imm",      out_imm,   32'h00008001);
      chk("bp.pc",       out_pc,    32'h00003000);
      chk("bp.in_ready", in_ready,  1'b0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp.release", in_ready, 1'b1);
    push(5'd9, 5'd3, 5'd2, 5'd0, 32'h8, 32'h00003004, 5'd9, 5'd0);
    cyc();
    in_valid = 1'b0;
    expect_out("bp_sw");

    // Flush beats a simultaneous input beat, even with out_ready low.
    out_ready = 1'b0;
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_instr  = 32'h3C071234;
    #1;
    chk("flush.in_ready", in_ready, 1'b0);
    cyc();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("flush.valid",  out_valid,  1'b0);
    chk("flush.op",     out_op,     5'd0);
    chk("flush.valid0", out_valid0, 1'b0);

    // Reset pulsed mid-stream clears outputs immediately; next beat decodes.
    in_valid = 1'b1;
    in_instr = 32'h0C000100;
    in_pc    = 32'h40000000;
    push(5'd13, 5'd0, 5'd0, 5'd31, 32'h40000400, 32'h40000000, 5'd13, 5'd31);
    cyc();
    in_instr = 32'h000520C0;
    in_pc    = 32'h00004000;
    expect_out("pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("arst");
    @(posedge clk);
    @(negedge clk);
    chk("arst.hold", out_valid, 1'b0);
    rst_n = 1'b1;
    push(5'd16, 5'd0, 5'd5, 5'd4, 32'h3, 32'h00004000, 5'd31, 5'd0);
    cyc();
    in_valid = 1'b0;
    expect_out("post_rst");

    chk("sb.drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
